// File: rtl/rf_wb_arbiter.sv
// Register-file write arbiter: pipeline writeback always wins, multi-cycle
// results fill idle slots, with starvation stall request and busy scoreboard.
module rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mc_valid,
  output logic            mc_ready,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            rf_RegWrite,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic [31:0]     busy_vec,
  output logic            stall_req,
  output logic            issue_conflict
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STARVE
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic [3:0]  cnt_inc;
  logic        mc_xfer;
  logic        mc_blocked;
  logic        mc_done;
  logic [31:0] busy_q;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;
  logic        we_q;
  logic [4:0]  rd_q;
  logic [XLEN-1:0] data_q;
  logic        stall_q;
  logic        conf_q;

  assign mc_ready   = !wb_valid && !RST;
  assign mc_xfer    = mc_valid && mc_ready;
  assign mc_blocked = mc_valid && !mc_ready;
  assign mc_done    = !mc_valid || mc_xfer;

  // Saturate rather than wrap so a long stall can never look short.
  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (mc_valid && wb_valid) begin
          state_d = WAIT;
          cnt_d   = 4'd1;
        end
      end
      WAIT: begin
        if (mc_done) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (mc_blocked) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= LIMIT) begin
            state_d = STARVE;
          end
        end
      end
      STARVE: begin
        if (mc_done) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (mc_blocked) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == STARVE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      we_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= '0;
    end else if (wb_valid) begin
      we_q   <= (wb_rd != 5'd0);
      rd_q   <= wb_rd;
      data_q <= wb_data;
    end else if (mc_xfer) begin
      we_q   <= (mc_rd != 5'd0);
      rd_q   <= mc_rd;
      data_q <= mc_data;
    end else begin
      we_q <= 1'b0;
    end
  end

  // x0 is never tracked; set wins over clear on the same bit.
  always_comb begin
    busy_set = 32'd0;
    busy_clr = 32'd0;
    if (issue_valid && issue_rd != 5'd0) begin
      busy_set = 32'd1 << issue_rd;
    end
    if (mc_xfer) begin
      busy_clr = 32'd1 << mc_rd;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q <= 32'd0;
      conf_q <= 1'b0;
    end else begin
      busy_q <= (busy_q & ~busy_clr) | busy_set;
      conf_q <= issue_valid && busy_q[issue_rd];
    end
  end

  assign rf_RegWrite    = we_q;
  assign rf_rd          = rd_q;
  assign rf_write_data  = data_q;
  assign busy_vec       = busy_q;
  assign stall_req      = stall_q;
  assign issue_conflict = conf_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed + random bench for rf_wb_arbiter against a behavioural model
// built from blocked-run lengths and a per-register busy array.
module tb_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [63:0] mc_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_RegWrite;
  logic [4:0]  rf_rd;
  logic [63:0] rf_write_data;
  logic [31:0] busy_vec;
  logic        stall_req;
  logic        issue_conflict;

  int vectors = 0;
  int miscompares = 0;

  bit          busy_m[32];
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [63:0] exp_data;
  logic        exp_conf;
  logic        exp_stall;
  int          run;

  always #5 CLK = ~CLK;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(64)) dut (
    .CLK(CLK), .RST(RST),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_rd(mc_rd), .mc_data(mc_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_RegWrite(rf_RegWrite), .rf_rd(rf_rd),
    .rf_write_data(rf_write_data), .busy_vec(busy_vec),
    .stall_req(stall_req), .issue_conflict(issue_conflict)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    logic [31:0] bv;
    for (int i = 0; i < 32; i++) bv[i] = busy_m[i];
    chk("rf_RegWrite", 64'(rf_RegWrite), 64'(exp_we));
    chk("rf_rd", 64'(rf_rd), 64'(exp_rd));
    chk("rf_write_data", rf_write_data, exp_data);
    chk("busy_vec", 64'(busy_vec), 64'(bv));
    chk("stall_req", 64'(stall_req), 64'(exp_stall));
    chk("issue_conflict", 64'(issue_conflict), 64'(exp_conf));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    exp_we = 0; exp_rd = 0; exp_data = 0;
    exp_conf = 0; exp_stall = 0; run = 0;
  endtask

  task automatic reset_step(input logic wv, input logic mv);
    RST = 1; wb_valid = wv; wb_rd = 5'd4; wb_data = 64'h55;
    mc_valid = mv; mc_rd = 5'd8; mc_data = 64'h77;
    issue_valid = 1; issue_rd = 5'd10;
    #1 chk("mc_ready_rst", 64'(mc_ready), 64'd0);
    model_reset();
    @(posedge CLK); #1;
    chk_outputs();
    RST = 0;
  endtask

  task automatic step(input logic wv, input logic [4:0] wrd,
                      input logic [63:0] wd, input logic mv,
                      input logic [4:0] mrd, input logic [63:0] md,
                      input logic iv, input logic [4:0] ird);
    logic xfer;
    logic blocked;
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    mc_valid = mv; mc_rd = mrd; mc_data = md;
    issue_valid = iv; issue_rd = ird;
    #1 chk("mc_ready", 64'(mc_ready), 64'(!wv));
    xfer = mv && !wv;
    blocked = mv && wv;
    if (wv) begin
      exp_we = (wrd != 0); exp_rd = wrd; exp_data = wd;
    end else if (xfer) begin
      exp_we = (mrd != 0); exp_rd = mrd; exp_data = md;
    end else begin
      exp_we = 0;
    end
    exp_conf = iv && busy_m[ird];
    if (xfer) busy_m[mrd] = 0;
    if (iv && ird != 0) busy_m[ird] = 1;
    run = blocked ? run + 1 : 0;
    exp_stall = blocked && (run >= LIMIT);
    @(posedge CLK); #1;
    chk_outputs();
  endtask

  initial begin
    bit          pend;
    logic [4:0]  prd;
    logic [63:0] pdata;
    logic        wv;
    logic        mv;

    RST = 1; wb_valid = 0; wb_rd = 0; wb_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    issue_valid = 0; issue_rd = 0;
    reset_step(0, 0);
    reset_step(1, 1);

    // wb then mc on the next cycle
    step(1, 5'd5, 64'hAA, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd6, 64'hBB, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // simultaneous offers: wb first, mc after wb drops
    step(1, 5'd3, 64'h33, 1, 5'd7, 64'h77, 0, 0);
    step(0, 0, 0, 1, 5'd7, 64'h77, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // starvation, then release
    for (int i = 0; i < 6; i++)
      step(1, 5'd1 + 5'(i), 64'(i), 1, 5'd12, 64'hC0C0, 0, 0);
    step(0, 0, 0, 1, 5'd12, 64'hC0C0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // busy scoreboard and conflicts
    step(0, 0, 0, 0, 0, 0, 1, 5'd9);
    step(0, 0, 0, 0, 0, 0, 1, 5'd9);
    step(0, 0, 0, 1, 5'd9, 64'h99, 1, 5'd9);
    step(0, 0, 0, 1, 5'd9, 64'h9A, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd0);

    // x0 writes
    step(1, 5'd0, 64'hDEAD, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5'd0, 64'hBEEF, 0, 0);

    // reset while starving
    for (int i = 0; i < 5; i++)
      step(1, 5'd2, 64'(i), 1, 5'd13, 64'hD0, 0, 0);
    reset_step(1, 1);
    step(0, 0, 0, 1, 5'd13, 64'hD0, 0, 0);

    pend = 0; prd = 0; pdata = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_step($urandom_range(0, 1) == 1, pend);
        pend = 0;
      end else begin
        if (!pend && $urandom_range(0, 2) == 0) begin
          pend = 1;
          prd = 5'($urandom_range(0, 11));
          pdata = {$urandom, $urandom};
        end else if (pend && $urandom_range(0, 15) == 0) begin
          pend = 0;
        end
        mv = pend;
        if (stall_req) wv = ($urandom_range(0, 3) == 0);
        else wv = ($urandom_range(0, 99) < 65);
        step(wv, 5'($urandom_range(0, 31)), {$urandom, $urandom},
             mv, prd, pdata,
             $urandom_range(0, 2) == 0, 5'($urandom_range(0, 11)));
        if (mv && !wv) pend = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive blocked mc cycles before stall_req asserts; legal range 1..15.
REQ-002 Parameter XLEN, default 64: data width.
REQ-003 The clock SHALL be CLK, input, 1 bit; all state updates on its rising edge.
REQ-004 The reset SHALL be RST, input, 1 bit, synchronous and active-high.
REQ-005 The pipeline writeback port SHALL be: wb_valid, input, 1 bit, writeback this cycle.
REQ-006 wb_rd, input, 5 bits: destination register.
REQ-007 wb_data, input, XLEN bits: writeback data.
REQ-008 The multi-cycle unit result port SHALL be: mc_valid, input, 1 bit, result offered.
REQ-009 mc_ready, output, 1 bit: result accepted this cycle.
REQ-010 mc_rd, input, 5 bits: result destination register.
REQ-011 mc_data, input, XLEN bits: result data.
REQ-012 The issue port SHALL be: issue_valid, input, 1 bit, multi-cycle op issued; and issue_rd, input, 5 bits, its destination.
REQ-013 The register-file drive SHALL be: rf_RegWrite, output, 1 bit; rf_rd, output, 5 bits; rf_write_data, output, XLEN bits.
REQ-014 busy_vec, output, 32 bits: bit n set while register n awaits a multi-cycle result.
REQ-015 stall_req, output, 1 bit: request that the front end inject writeback bubbles.
REQ-016 issue_conflict, output, 1 bit: one-cycle pulse, issue to an already-busy register.

Function
REQ-017 wb SHALL have absolute priority; the arbiter SHALL never back-pressure wb.
REQ-018 mc_ready SHALL be combinational: mc_ready = !wb_valid && !RST.
REQ-019 An mc transfer SHALL occur in a cycle where mc_valid && mc_ready; mc_rd/mc_data SHALL be held stable by the source until that cycle.
REQ-020 rf outputs SHALL be registered: a wb_valid or mc transfer in cycle N drives rf_RegWrite=1, rf_rd and rf_write_data from the winner in cycle N+1; otherwise rf_RegWrite=0 with rf_rd/rf_write_data holding their previous values.
REQ-021 A winning write with rd=0 SHALL complete its handshake but SHALL produce rf_RegWrite=0.
REQ-022 The FSM SHALL have states IDLE, WAIT, STARVE.
REQ-023 IDLE->WAIT when mc_valid && wb_valid; stays IDLE otherwise.
REQ-024 WAIT: a 4-bit counter increments each cycle with mc_valid && !mc_ready; WAIT->IDLE on mc transfer or mc_valid=0; WAIT->STARVE when the counter reaches STARVE_LIMIT.
REQ-025 stall_req SHALL be 1 exactly while in STARVE (registered, i.e. from the cycle after the limit is reached).
REQ-026 STARVE->IDLE on the cycle of mc transfer (stall_req drops the following cycle); STARVE->IDLE also if mc_valid drops.
REQ-027 The counter SHALL clear on entry to IDLE and SHALL saturate, never wrapping.
REQ-028 issue_valid with issue_rd!=0 SHALL set busy_vec[issue_rd] at the next edge; issue_rd=0 SHALL set nothing.
REQ-029 An mc transfer SHALL clear busy_vec[mc_rd] at the next edge; wb writes SHALL NOT alter busy_vec.
REQ-030 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-031 issue_valid to a register whose busy bit is already 1 SHALL pulse issue_conflict=1 in the next cycle; the busy bit stays 1.
REQ-032 All outputs other than mc_ready SHALL be driven from registers.

Reset
REQ-033 While RST=1: rf_RegWrite=0, rf_rd=0, rf_write_data=0, busy_vec=0, stall_req=0, issue_conflict=0, mc_ready=0, FSM=IDLE, counter=0.
REQ-034 Reset mid-operation SHALL drop any pending mc offer without a transfer and SHALL NOT produce a write in the cycle after reset deasserts.

Verification
REQ-035 Reset release, then wb_valid=1, rd=5, data=0xAA, followed next cycle by mc offer rd=6 -> rf_RegWrite cycle N+1 for x5=0xAA, then N+2 for x6.
REQ-036 wb_valid=1 and mc_valid=1 on the same cycle (rd 3/7) -> mc_ready=0, x3 written first; x7 written one cycle after wb_valid drops.
REQ-037 STARVE_LIMIT=4, wb_valid held high with mc_valid=1 -> stall_req rises after the 4th blocked cycle; drop wb_valid -> mc transfer occurs, stall_req falls next cycle, counter=0.
REQ-038 issue rd=9 -> busy_vec[9]=1; re-issue rd=9 -> issue_conflict pulse; mc result rd=9 with issue rd=9 in the same cycle -> busy_vec[9] stays 1.
REQ-039 wb rd=0 and mc rd=0 transfers -> handshakes complete, rf_RegWrite stays 0, busy_vec[0] stays 0.
REQ-040 Assert RST while in STARVE with mc_valid=1 -> next cycle all outputs at reset values, no write issued.
